// File: rtl/pipe_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Carries come from 4-bit lookahead groups combined by a two-level lookahead tree.
module pipe_cla_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             prop,
    output logic             gene,
    output logic             ovf
);

    localparam int NG = WIDTH / 4;        // 4-bit groups
    localparam int NS = (NG + 3) / 4;     // super-groups of four groups
    localparam int RW = WIDTH + 4;        // {ovf, gene, prop, cout, sum}
    localparam int NR = (STAGES == 1) ? 1 : STAGES - 1;

    // {group propagate, group generate} of a 4-wide slice.
    function automatic logic [1:0] grp_pg(input logic [3:0] p, input logic [3:0] g);
        logic gg;
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return {&p, gg};
    endfunction

    // Lookahead carry into position idx of a 4-wide slice, all terms in parallel.
    function automatic logic carry_into(input logic [2:0] p, input logic [2:0] g,
                                        input logic ci, input logic [1:0] idx);
        logic [3:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return c[idx];
    endfunction

    // Handshake: a beat moves on an edge with in_valid && in_ready; a result
    // leaves on an edge with out_valid && out_ready. The whole pipe advances
    // together when the output slot is empty or being drained, otherwise every
    // stage (bubbles included) holds.
    logic w_advance;
    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;

    logic [WIDTH-1:0] w_bb;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g;
    logic             w_c0;

    assign w_bb = sub ? ~b : b;
    assign w_c0 = sub | cin;
    assign w_p  = a ^ w_bb;
    assign w_g  = a & w_bb;

    logic [WIDTH-1:0] w_bp;
    logic [WIDTH-1:0] w_bg;
    logic             w_bc0;
    logic             w_bvld;

    generate
        if (STAGES == 1) begin : g_direct
            assign w_bp   = w_p;
            assign w_bg   = w_g;
            assign w_bc0  = w_c0;
            assign w_bvld = in_valid;
        end else begin : g_split
            logic [WIDTH-1:0] r_p;
            logic [WIDTH-1:0] r_g;
            logic             r_c0;
            logic             r_vld;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_p   <= '0;
                    r_g   <= '0;
                    r_c0  <= 1'b0;
                    r_vld <= 1'b0;
                end else if (w_advance) begin
                    r_p   <= w_p;
                    r_g   <= w_g;
                    r_c0  <= w_c0;
                    r_vld <= in_valid;
                end
            end

            assign w_bp   = r_p;
            assign w_bg   = r_g;
            assign w_bc0  = r_c0;
            assign w_bvld = r_vld;
        end
    endgenerate

    // Unused groups/super-groups are padded as pure propagate so they pass carries untouched.
    logic [15:0] w_gp16;
    logic [15:0] w_gg16;
    always_comb begin
        w_gp16 = '1;
        w_gg16 = '0;
        for (int k = 0; k < NG; k++) begin
            {w_gp16[k], w_gg16[k]} = grp_pg(w_bp[4*k +: 4], w_bg[4*k +: 4]);
        end
    end

    logic [3:0] w_sp;
    logic [3:0] w_sg;
    always_comb begin
        w_sp = '0;
        w_sg = '0;
        for (int s = 0; s < 4; s++) begin
            {w_sp[s], w_sg[s]} = grp_pg(w_gp16[4*s +: 4], w_gg16[4*s +: 4]);
        end
    end

    logic w_top_p;
    logic w_top_g;
    logic w_cout;
    assign {w_top_p, w_top_g} = grp_pg(w_sp, w_sg);
    assign w_cout = w_top_g | (w_top_p & w_bc0);

    logic [NS-1:0] w_cs;
    always_comb begin
        w_cs = '0;
        for (int s = 0; s < NS; s++) begin
            w_cs[s] = carry_into(w_sp[2:0], w_sg[2:0], w_bc0, 2'(s));
        end
    end

    logic [NG-1:0] w_cg;
    always_comb begin
        w_cg = '0;
        for (int k = 0; k < NG; k++) begin
            w_cg[k] = carry_into(w_gp16[4*(k/4) +: 3], w_gg16[4*(k/4) +: 3],
                                 w_cs[k/4], 2'(k % 4));
        end
    end

    logic [WIDTH-1:0] w_carry;
    always_comb begin
        w_carry = '0;
        for (int k = 0; k < NG; k++) begin
            for (int j = 0; j < 4; j++) begin
                w_carry[4*k+j] = carry_into(w_bp[4*k +: 3], w_bg[4*k +: 3], w_cg[k], 2'(j));
            end
        end
    end

    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;
    logic [RW-1:0]    w_res;
    assign w_sum = w_bp ^ w_carry;
    // Operand MSBs agree exactly when p[MSB]=0, and then a[MSB] equals g[MSB].
    assign w_ovf = ~w_bp[WIDTH-1] & (w_sum[WIDTH-1] ^ w_bg[WIDTH-1]);
    assign w_res = {w_ovf, w_top_g, w_top_p, w_cout, w_sum};

    logic [NR-1:0][RW-1:0] r_res;
    logic [NR-1:0]         r_rvld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res  <= '0;
            r_rvld <= '0;
        end else if (w_advance) begin
            r_res[0]  <= w_res;
            r_rvld[0] <= w_bvld;
            for (int i = 1; i < NR; i++) begin
                r_res[i]  <= r_res[i-1];
                r_rvld[i] <= r_rvld[i-1];
            end
        end
    end

    assign {ovf, gene, prop, cout, sum} = r_res[NR-1];
    assign out_valid = r_rvld[NR-1];

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Bench for pipe_cla_adder: directed vectors, stall/reset scenarios and random
// traffic on three configurations against an arithmetic reference model.
module tb_pipe_cla_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [63:0] a_l [3];
    logic [63:0] b_l [3];
    logic        iv_l [3];
    logic        cin_l [3];
    logic        sub_l [3];
    logic        ordy_l [3];
    logic        ir_l [3];
    logic        ov_l [3];
    logic [67:0] res_l [3];

    logic        ir0, ir1, ir2, ov0, ov1, ov2;
    logic        co0, co1, co2, pr0, pr1, pr2, ge0, ge1, ge2, of0, of1, of2;
    logic [15:0] sum0;
    logic [3:0]  sum1;
    logic [31:0] sum2;

    pipe_cla_adder #(.WIDTH(16), .STAGES(2)) u_dut (
        .clk(clk), .rst(rst), .in_valid(iv_l[0]), .in_ready(ir0),
        .a(a_l[0][15:0]), .b(b_l[0][15:0]), .cin(cin_l[0]), .sub(sub_l[0]),
        .out_valid(ov0), .out_ready(ordy_l[0]), .sum(sum0), .cout(co0),
        .prop(pr0), .gene(ge0), .ovf(of0)
    );

    pipe_cla_adder #(.WIDTH(4), .STAGES(1)) u_dut_w4 (
        .clk(clk), .rst(rst), .in_valid(iv_l[1]), .in_ready(ir1),
        .a(a_l[1][3:0]), .b(b_l[1][3:0]), .cin(cin_l[1]), .sub(sub_l[1]),
        .out_valid(ov1), .out_ready(ordy_l[1]), .sum(sum1), .cout(co1),
        .prop(pr1), .gene(ge1), .ovf(of1)
    );

    pipe_cla_adder #(.WIDTH(32), .STAGES(4)) u_dut_w32 (
        .clk(clk), .rst(rst), .in_valid(iv_l[2]), .in_ready(ir2),
        .a(a_l[2][31:0]), .b(b_l[2][31:0]), .cin(cin_l[2]), .sub(sub_l[2]),
        .out_valid(ov2), .out_ready(ordy_l[2]), .sum(sum2), .cout(co2),
        .prop(pr2), .gene(ge2), .ovf(of2)
    );

    assign ir_l[0]  = ir0;
    assign ir_l[1]  = ir1;
    assign ir_l[2]  = ir2;
    assign ov_l[0]  = ov0;
    assign ov_l[1]  = ov1;
    assign ov_l[2]  = ov2;
    assign res_l[0] = {of0, ge0, pr0, co0, 48'd0, sum0};
    assign res_l[1] = {of1, ge1, pr1, co1, 60'd0, sum1};
    assign res_l[2] = {of2, ge2, pr2, co2, 32'd0, sum2};

    // Reference: {ovf, gene, prop, cout, sum} from plain w-bit arithmetic.
    function automatic logic [67:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic cin, input logic sub);
        logic [64:0] mask, aa, bb, full, half;
        logic [63:0] s;
        logic        c0, cout, prop, gene, ovf;
        mask = (65'd1 << w) - 65'd1;
        aa   = {1'b0, a} & mask;
        bb   = sub ? (~{1'b0, b} & mask) : ({1'b0, b} & mask);
        c0   = sub ? 1'b1 : cin;
        full = aa + bb + {64'd0, c0};
        half = aa + bb;
        s    = full[63:0] & mask[63:0];
        cout = full[w];
        gene = half[w];
        prop = ((aa ^ bb) == mask);
        ovf  = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
        return {ovf, gene, prop, cout, s};
    endfunction

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            iv_l[i]   = 1'b0;
            ordy_l[i] = 1'b1;
            a_l[i]    = '0;
            b_l[i]    = '0;
            cin_l[i]  = 1'b0;
            sub_l[i]  = 1'b0;
        end
    endtask

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 9))
            0:       return '1;
            1:       return 64'd0;
            2:       return 64'd1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic new_beat(input int lane);
        a_l[lane]   = pick_operand();
        b_l[lane]   = pick_operand();
        cin_l[lane] = 1'($urandom_range(0, 1));
        sub_l[lane] = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        logic seen;
        rst = 1'b1;
        iv_l[0] = 1'b1;
        a_l[0] = 64'hFFFF;
        b_l[0] = 64'h0001;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ov_l[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_out_valid lane%0d: got %b expected 0", i, ov_l[i]);
            end
            checks++;
            if (res_l[i] !== 68'd0) begin
                errors++;
                $display("FAIL reset_outputs lane%0d: got %h expected 0", i, res_l[i]);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        iv_l[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (ir_l[0] !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b expected 1", ir_l[0]);
        end
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ov_l[0] !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_accept: got out_valid=1 expected 0");
        end
    endtask

    task automatic test_vectors();
        logic [15:0] va [4] = '{16'hFFFF, 16'hAAAA, 16'h0005, 16'h7FFF};
        logic [15:0] vb [4] = '{16'h0001, 16'h5555, 16'h0007, 16'h0001};
        logic        vc [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic        vs [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] vsum [4] = '{16'h0000, 16'h0000, 16'hFFFE, 16'h8000};
        logic [3:0]  vflg [4] = '{4'b0101, 4'b0011, 4'b0000, 4'b1000};
        logic [67:0] exp;
        for (int i = 0; i < 4; i++) begin
            exp = {vflg[i], 48'd0, vsum[i]};
            @(posedge clk);
            #1;
            iv_l[0] = 1'b1;
            a_l[0] = {48'd0, va[i]};
            b_l[0] = {48'd0, vb[i]};
            cin_l[0] = vc[i];
            sub_l[0] = vs[i];
            ordy_l[0] = 1'b1;
            @(negedge clk);
            checks++;
            if (ir_l[0] !== 1'b1) begin
                errors++;
                $display("FAIL vec%0d_in_ready: got %b expected 1", i, ir_l[0]);
            end
            @(posedge clk);
            #1;
            iv_l[0] = 1'b0;
            @(negedge clk);
            checks++;
            if (ov_l[0] !== 1'b0) begin
                errors++;
                $display("FAIL vec%0d_early: got out_valid=%b expected 0", i, ov_l[0]);
            end
            @(negedge clk);
            checks++;
            if (ov_l[0] !== 1'b1 || res_l[0] !== exp) begin
                errors++;
                $display("FAIL vec%0d_result: got v=%b %h expected v=1 %h", i, ov_l[0], res_l[0], exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [67:0] exp_q [$];
        logic [67:0] exp;
        int sent = 0, got = 0, done_cycle = 0;
        logic pending = 1'b0;
        for (int c = 1; c <= 40 && got < 20; c++) begin
            @(posedge clk);
            #1;
            ordy_l[0] = 1'b1;
            if (!pending && sent < 20) begin
                new_beat(0);
                iv_l[0] = 1'b1;
                pending = 1'b1;
            end else if (!pending) begin
                iv_l[0] = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (ir_l[0] !== 1'b1) begin
                errors++;
                $display("FAIL b2b_in_ready cycle%0d: got %b expected 1", c, ir_l[0]);
            end
            if (iv_l[0] && ir_l[0]) begin
                exp_q.push_back(model(16, a_l[0], b_l[0], cin_l[0], sub_l[0]));
                pending = 1'b0;
                sent++;
            end
            if (ov_l[0] && ordy_l[0]) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 68'h0;
                checks++;
                if (res_l[0] !== exp) begin
                    errors++;
                    $display("FAIL b2b_result%0d: got %h expected %h", got, res_l[0], exp);
                end
                got++;
                if (got == 20) done_cycle = c;
            end
        end
        iv_l[0] = 1'b0;
        checks++;
        if (done_cycle !== 22) begin
            errors++;
            $display("FAIL b2b_throughput: last result in cycle %0d expected 22", done_cycle);
        end
    endtask

    task automatic test_stall();
        logic [67:0] exp_q [$];
        logic [67:0] exp, hold;
        int sent = 0, got = 0;
        logic pending = 1'b0;
        hold = '0;
        for (int c = 1; c <= 40 && got < 5; c++) begin
            @(posedge clk);
            #1;
            if (!pending && sent < 5) begin
                new_beat(0);
                iv_l[0] = 1'b1;
                pending = 1'b1;
            end else if (!pending) begin
                iv_l[0] = 1'b0;
            end
            ordy_l[0] = !(c >= 3 && c <= 5);
            @(negedge clk);
            if (c >= 3 && c <= 5) begin
                checks++;
                if (ir_l[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_in_ready cycle%0d: got %b expected 0", c, ir_l[0]);
                end
            end
            if (c == 3) hold = res_l[0];
            if (c == 4 || c == 5) begin
                checks++;
                if (ov_l[0] !== 1'b1 || res_l[0] !== hold) begin
                    errors++;
                    $display("FAIL stall_hold cycle%0d: got v=%b %h expected v=1 %h", c, ov_l[0], res_l[0], hold);
                end
            end
            if (iv_l[0] && ir_l[0]) begin
                exp_q.push_back(model(16, a_l[0], b_l[0], cin_l[0], sub_l[0]));
                pending = 1'b0;
                sent++;
            end
            if (ov_l[0] && ordy_l[0]) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 68'h0;
                checks++;
                if (res_l[0] !== exp) begin
                    errors++;
                    $display("FAIL stall_result%0d: got %h expected %h", got, res_l[0], exp);
                end
                got++;
            end
        end
        iv_l[0] = 1'b0;
        ordy_l[0] = 1'b1;
        checks++;
        if (got !== 5) begin
            errors++;
            $display("FAIL stall_count: got %0d results expected 5", got);
        end
    endtask

    task automatic test_reset_mid();
        logic [67:0] exp;
        logic seen;
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk);
            #1;
            new_beat(0);
            iv_l[0] = 1'b1;
            ordy_l[0] = 1'b1;
            @(negedge clk);
            checks++;
            if (ir_l[0] !== 1'b1) begin
                errors++;
                $display("FAIL rstmid_accept%0d: got %b expected 1", c, ir_l[0]);
            end
        end
        @(posedge clk);
        #1;
        iv_l[0] = 1'b0;
        ordy_l[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ordy_l[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (ir_l[0] !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_in_ready: got %b expected 1", ir_l[0]);
        end
        seen = (ov_l[0] !== 1'b0);
        repeat (4) begin
            @(negedge clk);
            if (ov_l[0] !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_flushed: got out_valid=1 expected 0");
        end
        @(posedge clk);
        #1;
        new_beat(0);
        iv_l[0] = 1'b1;
        exp = model(16, a_l[0], b_l[0], cin_l[0], sub_l[0]);
        @(posedge clk);
        #1;
        iv_l[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (ov_l[0] !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_early: got out_valid=%b expected 0", ov_l[0]);
        end
        @(negedge clk);
        checks++;
        if (ov_l[0] !== 1'b1 || res_l[0] !== exp) begin
            errors++;
            $display("FAIL rstmid_result: got v=%b %h expected v=1 %h", ov_l[0], res_l[0], exp);
        end
    endtask

    task automatic test_random(input int lane, input int w, input int n);
        logic [67:0] exp_q [$];
        logic [67:0] exp;
        int sent = 0, got = 0, cycles = 0;
        logic pending = 1'b0;
        while (got < n && cycles < 20000) begin
            @(posedge clk);
            #1;
            cycles++;
            if (!pending && sent < n && $urandom_range(0, 3) != 0) begin
                new_beat(lane);
                iv_l[lane] = 1'b1;
                pending = 1'b1;
            end else if (!pending) begin
                iv_l[lane] = 1'b0;
            end
            ordy_l[lane] = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (iv_l[lane] && ir_l[lane]) begin
                exp_q.push_back(model(w, a_l[lane], b_l[lane], cin_l[lane], sub_l[lane]));
                pending = 1'b0;
                sent++;
            end
            if (ov_l[lane] && ordy_l[lane]) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 68'h0;
                checks++;
                if (res_l[lane] !== exp) begin
                    errors++;
                    $display("FAIL random_w%0d_beat%0d: got %h expected %h", w, got, res_l[lane], exp);
                end
                got++;
            end
        end
        iv_l[lane] = 1'b0;
        ordy_l[lane] = 1'b1;
        checks++;
        if (got !== n || exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_w%0d_count: got %0d results expected %0d", w, got, n);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        idle_all();
        rst = 1'b1;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_random(0, 16, 1000);
        test_random(1, 4, 1000);
        test_random(2, 32, 1000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
